peripheral_bus_bridge: RTL and testbench
========================================

PERIPHERAL_BUS_BRIDGE -- requirements
Module: peripheral_bus_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width of req_addr.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  master request valid.
REQ-005 req_ready  output  1  bridge accepts request; a transfer occurs when req_valid && req_ready.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 resp_valid / resp_ready  output / input  1 / 1  response handshake.
REQ-010 resp_rdata  output  32  read data; 0 for writes.
REQ-011 resp_error  output  1  error flag for the response.
REQ-012 count_we, count_config_we  output  1 each  one-cycle write strobes to the counter core.
REQ-013 count_in  output  32 ; count_en_in, count_dir_in, count_ire_in  output  1 each  write data to the core.
REQ-014 count_out  input  32 ; count_en_out, count_dir_out, count_ire_out, count_lt_1k_out  input  1 each  core readback.
REQ-015 mem_write_en  output  1 ; mem_address  output  8 ; mem_data_in  output  32 ; mem_data_out  input  32 (synchronous read, 1-cycle latency).

Function
REQ-016 Map (word offsets): 0x000 COUNT RW; 0x004 CONFIG RW, bit0 en, bit1 dir, bit2 ire; 0x008 STATUS RO, bit0 lt_1k; 0x400-0x7FC MEM window, mem_address = req_addr[9:2]; all other addresses unmapped.
REQ-017 FSM states IDLE, MEM_WAIT, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-018 IDLE + accepted register or unmapped access -> RESP next cycle.
REQ-019 IDLE + accepted MEM read -> MEM_WAIT (mem_address driven in acceptance cycle) -> RESP, capturing mem_data_out on the MEM_WAIT->RESP edge.
REQ-020 IDLE + accepted MEM write -> mem_write_en, mem_address, mem_data_in driven combinationally in acceptance cycle -> RESP next cycle.
REQ-021 COUNT/CONFIG writes register count_we/count_config_we high for exactly the one cycle after acceptance, with count_in = wdata and en/dir/ire_in = wdata[0]/[1]/[2].
REQ-022 Register reads capture core outputs at the acceptance edge; unused read bits are 0.
REQ-023 RESP holds resp_rdata and resp_error stable until resp_ready; RESP + resp_ready -> IDLE; a new request is not accepted in the same cycle.
REQ-024 Strobes and mem_write_en are never asserted outside the cycles given in REQ-020/021.

Reset
REQ-025 Reset asserted at any time, including mid-transaction, forces IDLE, drops the in-flight transfer with no response, and clears resp_rdata, resp_error, all strobes, and mem_write_en to 0.
REQ-026 After reset deassertion, req_ready = 1 on the first clock.

Configuration
REQ-027 Macro PERIPHERAL_BUS_BRIDGE_ERROR_EN defined: unmapped accesses and STATUS writes complete with resp_error = 1, rdata 0, and no side effects.
REQ-028 Macro undefined: the same accesses complete with resp_error = 0, rdata 0, and no side effects; resp_error is tied to 0.

Verification
REQ-029 Write 0x004 data 0x5, then read 0x004 -> count_config_we one-cycle pulse with en=1, dir=0, ire=1; read rdata 0x5, resp_valid one cycle after acceptance.
REQ-030 Write 0x000 data 0x12345678 -> count_we one-cycle pulse, count_in 0x12345678; read 0x008 with count_lt_1k_out=1 -> rdata 0x1.
REQ-031 Write MEM 0x404 data 0xDEADBEEF, then read 0x404 -> mem_address 1; read resp_valid two cycles after acceptance, rdata 0xDEADBEEF.
REQ-032 Read 0x100 -> rdata 0; resp_error 1 with macro defined, 0 without.
REQ-033 Hold resp_ready low 5 cycles -> resp_valid and rdata stable, req_ready 0 throughout; one cycle after resp_ready rises, req_ready returns to 1.
REQ-034 Assert reset in MEM_WAIT -> no response issued, resp_valid 0, req_ready 1 on the first clock after reset release.

Source files
------------

// File: rtl/peripheral_bus_bridge_if.sv
// rtl/peripheral_bus_bridge_if.sv - request/response bus between a master and the peripheral bus bridge
interface peripheral_bus_bridge_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/peripheral_bus_bridge.sv
// rtl/peripheral_bus_bridge.sv - bridges a valid/ready bus to counter-core registers and a word memory; PERIPHERAL_BUS_BRIDGE_ERROR_EN flags unmapped/illegal accesses
module peripheral_bus_bridge #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  peripheral_bus_bridge_if.slave bus,
  output logic        count_we,
  output logic        count_config_we,
  output logic [31:0] count_in,
  output logic        count_en_in,
  output logic        count_dir_in,
  output logic        count_ire_in,
  input  logic [31:0] count_out,
  input  logic        count_en_out,
  input  logic        count_dir_out,
  input  logic        count_ire_out,
  input  logic        count_lt_1k_out,
  output logic        mem_write_en,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic                  hit_count;
  logic                  hit_config;
  logic                  hit_status;
  logic                  hit_mem;
  logic                  accept;
  logic                  reg_write;
  logic [31:0]           reg_rdata;
  logic [31:0]           rdata_q;

  // Byte-lane bits are ignored, so decode on the word-aligned address.
  assign addr_word  = bus.req_addr & ~ADDR_WIDTH'(3);
  assign hit_count  = (addr_word == ADDR_WIDTH'('h000));
  assign hit_config = (addr_word == ADDR_WIDTH'('h004));
  assign hit_status = (addr_word == ADDR_WIDTH'('h008));
  assign hit_mem    = (addr_word >= ADDR_WIDTH'('h400)) && (addr_word <= ADDR_WIDTH'('h7FC));
  assign accept     = (state == IDLE) && bus.req_valid;
  assign reg_write  = accept && bus.req_write;

  // Register read mux; writes and unmapped reads return zero.
  always_comb begin
    reg_rdata = '0;
    if (!bus.req_write) begin
      if (hit_count)       reg_rdata = count_out;
      else if (hit_config) reg_rdata = {29'd0, count_ire_out, count_dir_out, count_en_out};
      else if (hit_status) reg_rdata = {31'd0, count_lt_1k_out};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: only memory reads need the extra cycle for the synchronous RAM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_next = (hit_mem && !bus.req_write) ? MEM_WAIT : RESP;
      end
      MEM_WAIT: state_next = RESP;
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: handshakes from state, memory port driven straight from the request.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    mem_write_en   = accept && bus.req_write && hit_mem;
    mem_address    = addr_word[9:2];
    mem_data_in    = bus.req_wdata;
  end

  // Response data: register reads latch at acceptance, memory reads latch leaving MEM_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 rdata_q <= '0;
    else if (accept)           rdata_q <= reg_rdata;
    else if (state == MEM_WAIT) rdata_q <= mem_data_out;
  end

  assign bus.resp_rdata = rdata_q;

`ifdef PERIPHERAL_BUS_BRIDGE_ERROR_EN
  logic error_q;
  logic err_cond;

  assign err_cond = !(hit_count || hit_config || hit_status || hit_mem) ||
                    (hit_status && bus.req_write);

  // Error flag latched with the request and held through the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       error_q <= 1'b0;
    else if (accept) error_q <= err_cond;
  end

  assign bus.resp_error = error_q;
`else
  assign bus.resp_error = 1'b0;
`endif

  // Core write strobes pulse for the single cycle after acceptance, with the data held alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_we        <= 1'b0;
      count_config_we <= 1'b0;
      count_in        <= '0;
      count_en_in     <= 1'b0;
      count_dir_in    <= 1'b0;
      count_ire_in    <= 1'b0;
    end else begin
      count_we        <= reg_write && hit_count;
      count_config_we <= reg_write && hit_config;
      if (reg_write && (hit_count || hit_config)) begin
        count_in     <= bus.req_wdata;
        count_en_in  <= bus.req_wdata[0];
        count_dir_in <= bus.req_wdata[1];
        count_ire_in <= bus.req_wdata[2];
      end
    end
  end

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// tb/tb_peripheral_bus_bridge.sv - vector-table bench for peripheral_bus_bridge with counter-core and RAM models
module tb_peripheral_bus_bridge;

`ifdef PERIPHERAL_BUS_BRIDGE_ERROR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        count_we, count_config_we;
  logic [31:0] count_in;
  logic        count_en_in, count_dir_in, count_ire_in;
  logic [31:0] count_out;
  logic [2:0]  core_cfg;
  logic        count_lt_1k_out;
  logic        mem_write_en;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [31:0] mem_arr [0:255];

  int errors = 0;
  int checks = 0;

  peripheral_bus_bridge_if #(.ADDR_WIDTH(12)) bus ();

  peripheral_bus_bridge #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .count_we(count_we), .count_config_we(count_config_we), .count_in(count_in),
    .count_en_in(count_en_in), .count_dir_in(count_dir_in), .count_ire_in(count_ire_in),
    .count_out(count_out), .count_en_out(core_cfg[0]), .count_dir_out(core_cfg[1]),
    .count_ire_out(core_cfg[2]), .count_lt_1k_out(count_lt_1k_out),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter core model: registers load on their strobes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out <= '0;
      core_cfg  <= '0;
    end else begin
      if (count_we)        count_out <= count_in;
      if (count_config_we) core_cfg  <= {count_ire_in, count_dir_in, count_en_in};
    end
  end
  assign count_lt_1k_out = (count_out < 32'd1000);

  // Synchronous RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_en) mem_arr[mem_address] <= mem_data_in;
    mem_data_out <= mem_arr[mem_address];
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_mwe;
    logic        chk_maddr;
    logic [7:0]  exp_maddr;
    logic        exp_cwe;
    logic        exp_ccwe;
    logic [31:0] exp_cin;
    logic [2:0]  exp_cfg;
  } vec_t;

  vec_t vecs [16];

  logic        acc_rdy, acc_mwe;
  logic [7:0]  acc_maddr;
  logic        p_cwe, p_ccwe;
  logic [31:0] p_cin;
  logic [2:0]  p_cfg;
  logic        post_str;
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;
  logic        seen_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction with resp_ready high; starts and ends at a negedge in IDLE.
  task automatic txn(input logic wr, input logic [11:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    acc_rdy   = bus.req_ready;
    acc_mwe   = mem_write_en;
    acc_maddr = mem_address;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    p_cwe  = count_we;
    p_ccwe = count_config_we;
    p_cin  = count_in;
    p_cfg  = {count_ire_in, count_dir_in, count_en_in};
    got_lat = 1;
    while (!bus.resp_valid && got_lat < 10) begin
      @(negedge clk);
      got_lat++;
    end
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_error;
    @(negedge clk);
    post_str = count_we | count_config_we | mem_write_en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    //           wr    addr     wdata         rdata         err   lat mwe   chk   maddr cwe   ccwe  cin           cfg
    vecs[0]  = '{1'b1, 12'h004, 32'h00000005, 32'h00000000, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000005, 3'b101};
    vecs[1]  = '{1'b0, 12'h004, 32'h00000000, 32'h00000005, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[2]  = '{1'b0, 12'h008, 32'h00000000, 32'h00000001, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[3]  = '{1'b1, 12'h000, 32'h12345678, 32'h00000000, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h12345678, 3'b000};
    vecs[4]  = '{1'b0, 12'h000, 32'h00000000, 32'h12345678, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[5]  = '{1'b0, 12'h008, 32'h00000000, 32'h00000000, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[6]  = '{1'b1, 12'h404, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[7]  = '{1'b0, 12'h404, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[8]  = '{1'b1, 12'h7FC, 32'h0A5A5A5A, 32'h00000000, 1'b0, 1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[9]  = '{1'b0, 12'h7FC, 32'h00000000, 32'h0A5A5A5A, 1'b0, 2, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[10] = '{1'b0, 12'h100, 32'h00000000, 32'h00000000, ERR,  1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[11] = '{1'b1, 12'h008, 32'hFFFFFFFF, 32'h00000000, ERR,  1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[12] = '{1'b1, 12'h3FC, 32'h00000001, 32'h00000000, ERR,  1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[13] = '{1'b0, 12'h800, 32'h00000000, 32'h00000000, ERR,  1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[14] = '{1'b0, 12'h406, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        3'b000};
    vecs[15] = '{1'b0, 12'h000, 32'h00000000, 32'h12345678, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'b000};

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'h1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'h0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset resp_error", 32'(bus.resp_error), 32'h0);
    check("reset strobes", 32'({count_we, count_config_we, mem_write_en}), 32'h0);
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d req_ready", i), 32'(acc_rdy), 32'h1);
      check($sformatf("v%0d mem_write_en", i), 32'(acc_mwe), 32'(vecs[i].exp_mwe));
      if (vecs[i].chk_maddr)
        check($sformatf("v%0d mem_address", i), 32'(acc_maddr), 32'(vecs[i].exp_maddr));
      check($sformatf("v%0d count_we", i), 32'(p_cwe), 32'(vecs[i].exp_cwe));
      check($sformatf("v%0d count_config_we", i), 32'(p_ccwe), 32'(vecs[i].exp_ccwe));
      if (vecs[i].exp_cwe || vecs[i].exp_ccwe)
        check($sformatf("v%0d count_in", i), p_cin, vecs[i].exp_cin);
      if (vecs[i].exp_ccwe)
        check($sformatf("v%0d cfg_in", i), 32'(p_cfg), 32'(vecs[i].exp_cfg));
      check($sformatf("v%0d latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d rdata", i), got_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d resp_error", i), 32'(got_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d strobes after", i), 32'(post_str), 32'h0);
    end

    // Backpressure: response held while resp_ready is low.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 12'h004;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d resp_valid", c), 32'(bus.resp_valid), 32'h1);
      check($sformatf("bp%0d rdata", c), bus.resp_rdata, 32'h5);
      check($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'h0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp release req_ready", 32'(bus.req_ready), 32'h1);
    check("bp release resp_valid", 32'(bus.resp_valid), 32'h0);

    // Reset while a response is pending clears it.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 12'h004;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_resp pre rdata", bus.resp_rdata, 32'h5);
    reset = 1'b1;
    #1;
    check("rst_resp resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp rdata", bus.resp_rdata, 32'h0);
    check("rst_resp error", 32'(bus.resp_error), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);

    // Reset during MEM_WAIT drops the read.
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h404;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mw in-wait resp_valid", 32'(bus.resp_valid), 32'h0);
    check("mw in-wait req_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mw after req_ready", 32'(bus.req_ready), 32'h1);
    seen_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen_valid |= bus.resp_valid;
      @(negedge clk);
    end
    check("mw no response", 32'(seen_valid), 32'h0);
    txn(1'b0, 12'h404, 32'h0);
    check("mw recover rdata", got_rdata, 32'hDEADBEEF);
    check("mw recover latency", 32'(got_lat), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
